ipsxe_fft_r2_burst_sched: RTL and testbench
===========================================

# ipsxe_fft_r2_burst_sched

Address and sequence controller for the radix-2 burst FFT core. It steps an in-place decimation-in-time transform through all stages. Each cycle it issues one butterfly's operand read addresses and twiddle ROM address, then regenerates the matching write-back addresses after the butterfly/complex-multiplier pipeline latency. It sits between the onboard test top / user control and the data RAM, twiddle ROM and `r2_dit` butterfly datapath. Input data is already in bit-reversed order in RAM.

## Interface
- `LOG2_FFT_LEN`, 10: log2 of the maximum transform length; sets address widths.
- `BF_LATENCY`, 6: cycles from RAM read address to butterfly result write (≥1).
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  start request, sampled only in IDLE.
- `i_log2_len`  in  4  log2 of run length L, latched on accepted start; values outside 3..`LOG2_FFT_LEN` are clamped into range.
- `i_scale_sch`  in  `LOG2_FFT_LEN`  per-stage scaling schedule; bit s applies to stage s. Latched on start.
- `o_busy`  out  1  high from the cycle after start acceptance until `o_done`, inclusive.
- `o_done`  out  1  one-cycle completion pulse.
- `o_rd_en`  out  1  butterfly operand read valid.
- `o_rd_addr_a`, `o_rd_addr_b`  out  `LOG2_FFT_LEN`  upper and lower operand addresses.
- `o_tw_addr`  out  `LOG2_FFT_LEN-1`  twiddle ROM index. The ROM is sized for the maximum length.
- `o_stage`  out  4  current stage index.
- `o_scale`  out  1  divide-by-2 enable for the butterfly, aligned with `o_rd_en`.
- `o_wr_en`  out  1  write-back valid.
- `o_wr_addr_a`, `o_wr_addr_b`  out  `LOG2_FFT_LEN`  write-back addresses.
- All outputs reset to 0.

## Operation
- States:
  - IDLE: on `i_start`, latch L and schedule; set s=0, k=0; go to RUN.
  - RUN: issue one butterfly per cycle for k = 0..2^(L-1)−1. After the last k, go to DRAIN.
  - DRAIN: hold `o_rd_en`=0 for exactly `BF_LATENCY` cycles, until the last write of the stage has issued. Then, if s<L−1, set s+1, k=0 and return to RUN; otherwise go to DONE.
  - DONE: assert `o_done` for one cycle, then go to IDLE.
- Address generation for stage s and butterfly k (span = 2^s, pos = k & (span−1), grp = k >> s):
  - addr_a = (grp << (s+1)) | pos
  - addr_b = addr_a + span
  - tw = pos << (`LOG2_FFT_LEN`−1−s)
- Address bits above L are always 0.
- Write path: `o_wr_en`, `o_wr_addr_a` and `o_wr_addr_b` are the read signals delayed by exactly `BF_LATENCY` through a shift register. No other write logic exists.
- Because of DRAIN, no read of stage s+1 ever occurs before the final write of stage s. There is no RAW hazard.
- `i_start` is ignored whenever the block is not in IDLE.
- Reset mid-run: the FSM returns to IDLE and the write-delay pipeline is flushed. `o_wr_en` is 0 from the cycle after `i_rst` and no stale writes emerge. RAM contents are undefined.

## Timing
- Accepted start at cycle 0 → first `o_rd_en` at cycle 1.
- Stage s reads occupy 2^(L-1) consecutive cycles, followed by a `BF_LATENCY`-cycle gap.
- `o_done` fires at cycle L·(2^(L-1)+`BF_LATENCY`)+1. `o_busy` falls the following cycle.
- Back-to-back operation: `i_start` sampled in the IDLE cycle after DONE is accepted, so there is one idle cycle between runs.
- Output addresses are registered. They are valid in the same cycle as their enable and stable only when the enable is high.

## Configuration
- `IPSXE_FFT_SCHED_SCALE_EN` defined: `o_scale` = latched `i_scale_sch[o_stage]` while `o_rd_en` is high, else 0.
- Not defined: `i_scale_sch` is unused, no schedule register is built, and `o_scale` is constant 0.

## Test plan
All scenarios use `LOG2_FFT_LEN`=10 and `BF_LATENCY`=2 unless noted.
- L=3 start:
  - Stage 0 pairs (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0.
  - Stage 1 pairs (0,2),(1,3),(4,6),(5,7), tw 0,256,0,256.
  - Stage 2 pairs (0,4),(1,5),(2,6),(3,7), tw 0,128,256,384.
  - `o_done` at cycle 19.
- Same run: every `o_wr_en` pulse and its addresses equal the read-side values from 2 cycles earlier. `o_rd_en` is low for cycles 5–6 and 11–12.
- `i_log2_len`=1 → runs as L=3 (clamped). `i_log2_len`=15 → runs as L=10, with `o_done` at cycle 10·(512+2)+1 = 5141.
- `i_start` pulsed during RUN → ignored, and the cycle count is unchanged. With `i_start` held high, a second run starts the cycle after `o_done`.
- `i_rst` asserted at cycle 8 of an L=3 run → from cycle 9, all outputs are 0, `o_wr_en` stays 0, and the next start behaves as from power-up.
- With the macro defined and `i_scale_sch`=3'b101, `o_scale` is 1 during stage 0 and stage 2 reads only. Without the macro it is always 0.

Source files
------------

// File: rtl/ipsxe_fft_r2_burst_sched.sv
// Radix-2 DIT burst FFT address/sequence controller: one butterfly per cycle, write-back delayed by BF_LATENCY.
// Optional per-stage scaling output is built only when IPSXE_FFT_SCHED_SCALE_EN is defined.
module ipsxe_fft_r2_burst_sched #(
  parameter int LOG2_FFT_LEN = 10,
  parameter int BF_LATENCY   = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [3:0]                i_log2_len,
  input  logic [LOG2_FFT_LEN-1:0]   i_scale_sch,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_rd_en,
  output logic [LOG2_FFT_LEN-1:0]   o_rd_addr_a,
  output logic [LOG2_FFT_LEN-1:0]   o_rd_addr_b,
  output logic [LOG2_FFT_LEN-2:0]   o_tw_addr,
  output logic [3:0]                o_stage,
  output logic                      o_scale,
  output logic                      o_wr_en,
  output logic [LOG2_FFT_LEN-1:0]   o_wr_addr_a,
  output logic [LOG2_FFT_LEN-1:0]   o_wr_addr_b
);
  localparam int AW = LOG2_FFT_LEN;
  localparam int KW = LOG2_FFT_LEN - 1;
  localparam int CW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_nstate;
  logic [3:0]      r_len, w_nlen;
  logic [3:0]      r_stage, w_ns;
  logic [KW-1:0]   r_k, w_nk;
  logic [CW-1:0]   r_cnt, w_ncnt;
  logic            w_issue, w_ndone, w_scale;

  logic            r_busy, r_done, r_rd_en, r_scale;
  logic [AW-1:0]   r_rd_a, r_rd_b;
  logic [KW-1:0]   r_tw;

  logic [3:0]      w_len_clamp;
  logic [KW-1:0]   w_k_max, w_mask, w_pos, w_grp, w_tw;
  logic [AW-1:0]   w_addr_a, w_addr_b;

  assign w_len_clamp = (i_log2_len < 4'd3) ? 4'd3 :
                       (i_log2_len > 4'(LOG2_FFT_LEN)) ? 4'(LOG2_FFT_LEN) : i_log2_len;
  // Wraps to all-ones at the maximum length, which is the intended last index.
  assign w_k_max = (KW'(1) << (r_len - 4'd1)) - KW'(1);

  always_comb begin
    w_nstate = r_state;
    w_nlen   = r_len;
    w_ns     = r_stage;
    w_nk     = r_k;
    w_ncnt   = r_cnt;
    w_issue  = 1'b0;
    w_ndone  = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_nlen   = w_len_clamp;
        w_ns     = 4'd0;
        w_nk     = '0;
        w_issue  = 1'b1;
        w_nstate = S_RUN;
      end
      S_RUN: if (r_k == w_k_max) begin
        w_ncnt   = '0;
        w_nstate = S_DRAIN;
      end else begin
        w_nk    = r_k + KW'(1);
        w_issue = 1'b1;
      end
      S_DRAIN: if (r_cnt == CW'(BF_LATENCY - 1)) begin
        if (r_stage < r_len - 4'd1) begin
          w_ns     = r_stage + 4'd1;
          w_nk     = '0;
          w_issue  = 1'b1;
          w_nstate = S_RUN;
        end else begin
          w_ndone  = 1'b1;
          w_nstate = S_DONE;
        end
      end else begin
        w_ncnt = r_cnt + CW'(1);
      end
      S_DONE: w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // addr_a inserts a zero bit at position s of k; addr_b sets that bit.
  assign w_mask   = (KW'(1) << w_ns) - KW'(1);
  assign w_pos    = w_nk & w_mask;
  assign w_grp    = w_nk >> w_ns;
  assign w_addr_a = (AW'(w_grp) << (w_ns + 4'd1)) | AW'(w_pos);
  assign w_addr_b = w_addr_a + (AW'(1) << w_ns);
  assign w_tw     = w_pos << (4'(LOG2_FFT_LEN - 1) - w_ns);

`ifdef IPSXE_FFT_SCHED_SCALE_EN
  logic [AW-1:0] r_sch, w_sch_cur;
  assign w_sch_cur = (r_state == S_IDLE) ? i_scale_sch : r_sch;
  assign w_scale   = w_issue & w_sch_cur[w_ns];
  always_ff @(posedge i_clk) begin
    if (i_rst)                            r_sch <= '0;
    else if (r_state == S_IDLE && i_start) r_sch <= i_scale_sch;
  end
`else
  logic w_unused_sch;
  assign w_unused_sch = ^i_scale_sch;
  assign w_scale      = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_stage <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_tw    <= '0;
      r_scale <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_len   <= w_nlen;
      r_stage <= w_ns;
      r_k     <= w_nk;
      r_cnt   <= w_ncnt;
      r_busy  <= (w_nstate != S_IDLE);
      r_done  <= w_ndone;
      r_rd_en <= w_issue;
      r_rd_a  <= w_issue ? w_addr_a : '0;
      r_rd_b  <= w_issue ? w_addr_b : '0;
      r_tw    <= w_issue ? w_tw : '0;
      r_scale <= w_scale;
    end
  end

  // Write-back is purely the read side delayed; reset flushes any in-flight writes.
  logic [BF_LATENCY-1:0]         r_wv;
  logic [BF_LATENCY-1:0][AW-1:0] r_wa, r_wb;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wv <= '0;
      r_wa <= '0;
      r_wb <= '0;
    end else begin
      r_wv[0] <= r_rd_en;
      r_wa[0] <= r_rd_a;
      r_wb[0] <= r_rd_b;
      for (int i = 1; i < BF_LATENCY; i++) begin
        r_wv[i] <= r_wv[i-1];
        r_wa[i] <= r_wa[i-1];
        r_wb[i] <= r_wb[i-1];
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rd_en     = r_rd_en;
  assign o_rd_addr_a = r_rd_a;
  assign o_rd_addr_b = r_rd_b;
  assign o_tw_addr   = r_tw;
  assign o_stage     = r_stage;
  assign o_scale     = r_scale;
  assign o_wr_en     = r_wv[BF_LATENCY-1];
  assign o_wr_addr_a = r_wa[BF_LATENCY-1];
  assign o_wr_addr_b = r_wb[BF_LATENCY-1];
endmodule

// File: tb/tb_ipsxe_fft_r2_burst_sched.sv
// Self-checking bench for ipsxe_fft_r2_burst_sched: per-cycle comparison against a stage/butterfly timeline model.
module tb_ipsxe_fft_r2_burst_sched;
  localparam int LOG2 = 10;
  localparam int BL   = 2;
  localparam int AW   = LOG2;
  localparam int MAXC = 5300;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [3:0]      log2_len;
  logic [AW-1:0]   sch;
  logic            busy, done, rd_en, scale, wr_en;
  logic [AW-1:0]   rd_a, rd_b, wr_a, wr_b;
  logic [AW-2:0]   tw;
  logic [3:0]      stage;

  int n_checks = 0;
  int n_fail   = 0;

  logic          exp_en [MAXC];
  logic [AW-1:0] exp_a  [MAXC];
  logic [AW-1:0] exp_b  [MAXC];
  logic [AW-2:0] exp_tw [MAXC];
  logic [3:0]    exp_st [MAXC];
  logic          exp_sc [MAXC];
  int            done_cyc;

  ipsxe_fft_r2_burst_sched #(.LOG2_FFT_LEN(LOG2), .BF_LATENCY(BL)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_log2_len(log2_len), .i_scale_sch(sch),
    .o_busy(busy), .o_done(done), .o_rd_en(rd_en), .o_rd_addr_a(rd_a), .o_rd_addr_b(rd_b),
    .o_tw_addr(tw), .o_stage(stage), .o_scale(scale), .o_wr_en(wr_en),
    .o_wr_addr_a(wr_a), .o_wr_addr_b(wr_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Timeline: cycle 1 is the first read; each stage is 2^(L-1) reads then BL idle cycles.
  task automatic build_model(input int L, input logic [AW-1:0] s_sch);
    int c, span, half;
    for (int i = 0; i < MAXC; i++) begin
      exp_en[i] = 0; exp_a[i] = 0; exp_b[i] = 0; exp_tw[i] = 0; exp_st[i] = 0; exp_sc[i] = 0;
    end
    c = 1;
    half = 1 << (L - 1);
    for (int s = 0; s < L; s++) begin
      span = 1 << s;
      for (int k = 0; k < half; k++) begin
        exp_en[c] = 1'b1;
        exp_a[c]  = AW'((k / span) * 2 * span + (k % span));
        exp_b[c]  = AW'((k / span) * 2 * span + (k % span) + span);
        exp_tw[c] = (AW-1)'((k % span) * ((1 << (LOG2 - 1)) / span));
        exp_st[c] = 4'(s);
`ifdef IPSXE_FFT_SCHED_SCALE_EN
        exp_sc[c] = s_sch[s];
`else
        exp_sc[c] = 1'b0;
`endif
        c++;
      end
      c += BL;
    end
    done_cyc = c;
  endtask

  // mode 0: single start pulse; 1: extra start pulses mid-run; 2: start held high at exit.
  task automatic run_check(input logic [3:0] lin, input int lexp, input logic [AW-1:0] s,
                           input int mode, output int obs_done);
    logic ew;
    build_model(lexp, s);
    log2_len = lin;
    sch      = s;
    start    = 1'b1;
    step();
    if (mode != 2) start = 1'b0;
    obs_done = -1;
    for (int c = 1; c <= done_cyc + 1; c++) begin
      if (mode == 1) start = (c == 3 || c == done_cyc / 2);
      n_checks++;
      if (rd_en !== exp_en[c]) begin
        n_fail++; $display("FAIL rd_en cyc %0d: got %b want %b", c, rd_en, exp_en[c]);
      end
      if (exp_en[c]) begin
        n_checks++;
        if (rd_a !== exp_a[c] || rd_b !== exp_b[c] || tw !== exp_tw[c] || stage !== exp_st[c]) begin
          n_fail++;
          $display("FAIL rd_addr cyc %0d: got a=%0d b=%0d tw=%0d st=%0d want a=%0d b=%0d tw=%0d st=%0d",
                   c, rd_a, rd_b, tw, stage, exp_a[c], exp_b[c], exp_tw[c], exp_st[c]);
        end
      end
      n_checks++;
      if (scale !== exp_sc[c]) begin
        n_fail++; $display("FAIL scale cyc %0d: got %b want %b", c, scale, exp_sc[c]);
      end
      ew = (c > BL) ? exp_en[c-BL] : 1'b0;
      n_checks++;
      if (wr_en !== ew) begin
        n_fail++; $display("FAIL wr_en cyc %0d: got %b want %b", c, wr_en, ew);
      end
      if (ew) begin
        n_checks++;
        if (wr_a !== exp_a[c-BL] || wr_b !== exp_b[c-BL]) begin
          n_fail++;
          $display("FAIL wr_addr cyc %0d: got a=%0d b=%0d want a=%0d b=%0d",
                   c, wr_a, wr_b, exp_a[c-BL], exp_b[c-BL]);
        end
      end
      n_checks++;
      if (done !== (c == done_cyc)) begin
        n_fail++; $display("FAIL done cyc %0d: got %b want %b", c, done, (c == done_cyc));
      end
      if (done === 1'b1 && obs_done < 0) obs_done = c;
      n_checks++;
      if (busy !== (c <= done_cyc)) begin
        n_fail++; $display("FAIL busy cyc %0d: got %b want %b", c, busy, (c <= done_cyc));
      end
      if (c <= done_cyc) step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({busy, done, rd_en, scale, wr_en} !== 5'b0 || rd_a !== '0 || rd_b !== '0 ||
        tw !== '0 || stage !== '0 || wr_a !== '0 || wr_b !== '0) begin
      n_fail++;
      $display("FAIL %s: got busy=%b done=%b rd=%b sc=%b wr=%b a=%0d b=%0d tw=%0d st=%0d wa=%0d wb=%0d want all 0",
               tag, busy, done, rd_en, scale, wr_en, rd_a, rd_b, tw, stage, wr_a, wr_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; log2_len = 4'd3; sch = '0;
    repeat (3) step();
    rst = 1'b0;
    check_all_zero("reset_state");
    step();
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_l3();
    int od;
    run_check(4'd3, 3, AW'(3'b101), 0, od);
    n_checks++;
    if (od !== 19) begin n_fail++; $display("FAIL l3_done_cycle: got %0d want 19", od); end
  endtask

  task automatic test_start_ignored();
    int od;
    run_check(4'd4, 4, AW'($urandom), 1, od);
    n_checks++;
    if (od !== 4 * (8 + BL) + 1) begin
      n_fail++; $display("FAIL start_ignored_done: got %0d want %0d", od, 4 * (8 + BL) + 1);
    end
  endtask

  task automatic test_clamp();
    int od;
    run_check(4'd1, 3, AW'($urandom), 0, od);
    n_checks++;
    if (od !== 19) begin n_fail++; $display("FAIL clamp_low_done: got %0d want 19", od); end
    run_check(4'd15, 10, AW'($urandom), 0, od);
    n_checks++;
    if (od !== 5141) begin n_fail++; $display("FAIL clamp_high_done: got %0d want 5141", od); end
  endtask

  task automatic test_random();
    int od, L;
    for (int i = 0; i < 4; i++) begin
      L = $urandom_range(3, 7);
      run_check(4'(L), L, AW'($urandom), $urandom_range(0, 1), od);
    end
  endtask

  task automatic test_back_to_back();
    int od;
    run_check(4'd3, 3, AW'($urandom), 2, od);
    run_check(4'd5, 5, AW'($urandom), 0, od);
    n_checks++;
    if (od !== 5 * (16 + BL) + 1) begin
      n_fail++; $display("FAIL b2b_done: got %0d want %0d", od, 5 * (16 + BL) + 1);
    end
  endtask

  task automatic test_reset_midrun();
    int od;
    log2_len = 4'd3; sch = AW'(3'b111); start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    n_checks++;
    if (rd_en !== 1'b1 || rd_a !== AW'(1) || rd_b !== AW'(3)) begin
      n_fail++; $display("FAIL midrun_pre_reset: got rd=%b a=%0d b=%0d want 1 1 3", rd_en, rd_a, rd_b);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_all_zero("after_midrun_reset");
      step();
    end
    run_check(4'd3, 3, AW'(3'b101), 0, od);
    n_checks++;
    if (od !== 19) begin n_fail++; $display("FAIL post_reset_done: got %0d want 19", od); end
  endtask

  initial begin
    test_reset();
    test_l3();
    test_start_ignored();
    test_clamp();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
